// File: rtl/mips_multicycle_controller_if.sv
// Datapath <-> controller bundle for the multi-cycle MIPS.
//   master : controller side (consumes opcode/func/zero, drives controls)
//   slave  : datapath side (drives opcode/func/zero, consumes controls)
// AluOperation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
interface mips_multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       PCLoad;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       R31;
  logic       MemToReg;
  logic       WriteLink;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluOperation;
  logic [1:0] PCSrc;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  opcode, func, zero,
    output PCLoad, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, R31,
           MemToReg, WriteLink, AluSrcA, AluSrcB, AluOperation, PCSrc,
           InstrDone, Illegal, State
  );

  modport slave (
    output opcode, func, zero,
    input  PCLoad, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, R31,
           MemToReg, WriteLink, AluSrcA, AluSrcB, AluOperation, PCSrc,
           InstrDone, Illegal, State
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (state -> FETCH, all outputs 0)
//   bus : master side of mips_multicycle_controller_if (opcode/func/zero in,
//         mux selects, write enables, ALU op, PCLoad, InstrDone, Illegal,
//         State out)
module mips_multicycle_controller (
  input  logic                         clk,
  input  logic                         rst,
  mips_multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;

  // Instruction decode shared by the next-state and output processes.
  state_e     dec_next;
  logic       dec_illegal;
  logic [2:0] rtype_alu_op;

  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b1;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.func)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            dec_next    = S_RTYPE_EX;
            dec_illegal = 1'b0;
          end
          F_JR: begin
            dec_next    = S_JR;
            dec_illegal = 1'b0;
          end
          default: ;
        endcase
      end
      OP_LW, OP_SW: begin
        dec_next    = S_MEMADR;
        dec_illegal = 1'b0;
      end
      OP_BEQ: begin
        dec_next    = S_BEQ;
        dec_illegal = 1'b0;
      end
      OP_ADDI, OP_SLTI: begin
        dec_next    = S_IMM_EX;
        dec_illegal = 1'b0;
      end
      OP_J: begin
        dec_next    = S_JUMP;
        dec_illegal = 1'b0;
      end
      OP_JAL: begin
        dec_next    = S_JAL;
        dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (bus.func)
      F_SUB:   rtype_alu_op = ALU_SUB;
      F_AND:   rtype_alu_op = ALU_AND;
      F_OR:    rtype_alu_op = ALU_OR;
      F_SLT:   rtype_alu_op = ALU_SLT;
      default: rtype_alu_op = ALU_ADD;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = dec_next;
      S_MEMADR:   state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output logic
  logic       pc_write, pc_write_cond;
  logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, r31;
  logic       mem_to_reg, write_link, alu_src_a, instr_done, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    r31           = 1'b0;
    mem_to_reg    = 1'b0;
    write_link    = 1'b0;
    alu_src_a     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = dec_illegal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = rtype_alu_op;
      end
      S_RTYPE_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (bus.opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_IMM_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        r31        = 1'b1;
        write_link = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = 2'b11;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: alu_op = '0;
    endcase
  end

  // Reset masks every output combinationally so nothing (FETCH enables
  // included) is driven while rst is high, without waiting for a clock.
  assign bus.PCLoad       = ~rst & (pc_write | (pc_write_cond & bus.zero));
  assign bus.IorD         = ~rst & iord;
  assign bus.MemRead      = ~rst & mem_read;
  assign bus.MemWrite     = ~rst & mem_write;
  assign bus.IRWrite      = ~rst & ir_write;
  assign bus.RegWrite     = ~rst & reg_write;
  assign bus.RegDst       = ~rst & reg_dst;
  assign bus.R31          = ~rst & r31;
  assign bus.MemToReg     = ~rst & mem_to_reg;
  assign bus.WriteLink    = ~rst & write_link;
  assign bus.AluSrcA      = ~rst & alu_src_a;
  assign bus.InstrDone    = ~rst & instr_done;
  assign bus.Illegal      = ~rst & illegal;
  assign bus.AluSrcB      = rst ? '0 : alu_src_b;
  assign bus.PCSrc        = rst ? '0 : pc_src;
  assign bus.AluOperation = rst ? '0 : alu_op;
  assign bus.State        = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: steps instructions one
// cycle at a time and compares State plus the full output vector against
// hand-written per-state expectations.
module tb_mips_multicycle_controller;

  logic clk;
  logic rst;

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout: PCLoad IorD MemRead MemWrite IRWrite RegWrite RegDst R31
  //         MemToReg WriteLink AluSrcA AluSrcB[1:0] AluOp[2:0] PCSrc[1:0]
  //         InstrDone Illegal
  logic [19:0] outs;
  assign outs = {bus.PCLoad, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                 bus.RegWrite, bus.RegDst, bus.R31, bus.MemToReg, bus.WriteLink,
                 bus.AluSrcA, bus.AluSrcB, bus.AluOperation, bus.PCSrc,
                 bus.InstrDone, bus.Illegal};

  //                                P I M M I R R R M W A SB AOP PS D I
  localparam logic [19:0] V_FETCH   = 20'b1_0_1_0_1_0_0_0_0_0_0_01_010_00_0_0;
  localparam logic [19:0] V_DEC     = 20'b0_0_0_0_0_0_0_0_0_0_0_11_010_00_0_0;
  localparam logic [19:0] V_DEC_ILL = 20'b0_0_0_0_0_0_0_0_0_0_0_11_010_00_0_1;
  localparam logic [19:0] V_MEMADR  = 20'b0_0_0_0_0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] V_MEMRD   = 20'b0_1_1_0_0_0_0_0_0_0_0_00_010_00_0_0;
  localparam logic [19:0] V_MEMWB   = 20'b0_0_0_0_0_1_0_0_1_0_0_00_010_00_1_0;
  localparam logic [19:0] V_MEMWR   = 20'b0_1_0_1_0_0_0_0_0_0_0_00_010_00_1_0;
  localparam logic [19:0] V_REX_ADD = 20'b0_0_0_0_0_0_0_0_0_0_1_00_010_00_0_0;
  localparam logic [19:0] V_REX_SUB = 20'b0_0_0_0_0_0_0_0_0_0_1_00_110_00_0_0;
  localparam logic [19:0] V_RWB     = 20'b0_0_0_0_0_1_1_0_0_0_0_00_010_00_1_0;
  localparam logic [19:0] V_BEQ_T   = 20'b1_0_0_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [19:0] V_BEQ_N   = 20'b0_0_0_0_0_0_0_0_0_0_1_00_110_01_1_0;
  localparam logic [19:0] V_IEX_SLT = 20'b0_0_0_0_0_0_0_0_0_0_1_10_111_00_0_0;
  localparam logic [19:0] V_IEX_ADD = 20'b0_0_0_0_0_0_0_0_0_0_1_10_010_00_0_0;
  localparam logic [19:0] V_IWB     = 20'b0_0_0_0_0_1_0_0_0_0_0_00_010_00_1_0;
  localparam logic [19:0] V_JUMP    = 20'b1_0_0_0_0_0_0_0_0_0_0_00_010_10_1_0;
  localparam logic [19:0] V_JAL     = 20'b1_0_0_0_0_1_0_1_0_1_0_00_010_10_1_0;
  localparam logic [19:0] V_JR      = 20'b1_0_0_0_0_0_0_0_0_0_0_00_010_11_1_0;

  int unsigned n_total;
  int unsigned n_bad;

  task automatic check(input string tag, input logic [19:0] act, input logic [19:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h want %05h", tag, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already applied; checks the
  // current cycle and advances to the next falling edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [19:0] v);
    #1;
    check({tag, ".state"}, 20'(bus.State), 20'(st));
    check({tag, ".outs"}, outs, v);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op;
    bus.func   = fn;
    bus.zero   = z;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    set_instr(6'b000000, 6'b100000, 1'b0);

    @(negedge clk);
    #1;
    check("rst.state", 20'(bus.State), 20'd0);
    check("rst.outs", outs, 20'd0);
    @(negedge clk);
    rst = 1'b0;

    // add, with zero high to show PCLoad ignores it outside BEQ
    set_instr(6'b000000, 6'b100000, 1'b1);
    step("add.f", 4'd0, V_FETCH);
    step("add.d", 4'd1, V_DEC);
    step("add.ex", 4'd6, V_REX_ADD);
    step("add.wb", 4'd7, V_RWB);

    set_instr(6'b100011, 6'b000000, 1'b0);
    step("lw.f", 4'd0, V_FETCH);
    step("lw.d", 4'd1, V_DEC);
    step("lw.ma", 4'd2, V_MEMADR);
    step("lw.rd", 4'd3, V_MEMRD);
    step("lw.wb", 4'd4, V_MEMWB);

    set_instr(6'b101011, 6'b000000, 1'b0);
    step("sw.f", 4'd0, V_FETCH);
    step("sw.d", 4'd1, V_DEC);
    step("sw.ma", 4'd2, V_MEMADR);
    step("sw.wr", 4'd5, V_MEMWR);

    set_instr(6'b000100, 6'b000000, 1'b1);
    step("beq1.f", 4'd0, V_FETCH);
    step("beq1.d", 4'd1, V_DEC);
    step("beq1.br", 4'd8, V_BEQ_T);

    set_instr(6'b000100, 6'b000000, 1'b0);
    step("beq0.f", 4'd0, V_FETCH);
    step("beq0.d", 4'd1, V_DEC);
    step("beq0.br", 4'd8, V_BEQ_N);

    set_instr(6'b000011, 6'b000000, 1'b0);
    step("jal.f", 4'd0, V_FETCH);
    step("jal.d", 4'd1, V_DEC);
    step("jal.x", 4'd12, V_JAL);

    set_instr(6'b000000, 6'b001000, 1'b0);
    step("jr.f", 4'd0, V_FETCH);
    step("jr.d", 4'd1, V_DEC);
    step("jr.x", 4'd13, V_JR);

    set_instr(6'b000010, 6'b000000, 1'b0);
    step("j.f", 4'd0, V_FETCH);
    step("j.d", 4'd1, V_DEC);
    step("j.x", 4'd11, V_JUMP);

    set_instr(6'b111111, 6'b000000, 1'b0);
    step("ill.f", 4'd0, V_FETCH);
    step("ill.d", 4'd1, V_DEC_ILL);

    // R-type with an unsupported func is illegal too
    set_instr(6'b000000, 6'b000000, 1'b0);
    step("illr.f", 4'd0, V_FETCH);
    step("illr.d", 4'd1, V_DEC_ILL);

    set_instr(6'b001010, 6'b000000, 1'b0);
    step("slti.f", 4'd0, V_FETCH);
    step("slti.d", 4'd1, V_DEC);
    step("slti.ex", 4'd9, V_IEX_SLT);
    step("slti.wb", 4'd10, V_IWB);

    // addi whose func field happens to equal the jr code: must stay addi
    set_instr(6'b001000, 6'b001000, 1'b0);
    step("addi.f", 4'd0, V_FETCH);
    step("addi.d", 4'd1, V_DEC);
    step("addi.ex", 4'd9, V_IEX_ADD);
    step("addi.wb", 4'd10, V_IWB);

    set_instr(6'b000000, 6'b100010, 1'b0);
    step("sub.f", 4'd0, V_FETCH);
    step("sub.d", 4'd1, V_DEC);
    step("sub.ex", 4'd6, V_REX_SUB);
    step("sub.wb", 4'd7, V_RWB);

    // lw aborted by reset in MEMRD, between clock edges
    set_instr(6'b100011, 6'b000000, 1'b0);
    step("abrt.f", 4'd0, V_FETCH);
    step("abrt.d", 4'd1, V_DEC);
    step("abrt.ma", 4'd2, V_MEMADR);
    #1;
    check("abrt.rd.state", 20'(bus.State), 20'd3);
    #1;
    rst = 1'b1;
    #1;
    check("abrt.rst.state", 20'(bus.State), 20'd0);
    check("abrt.rst.outs", outs, 20'd0);
    @(negedge clk);
    rst = 1'b0;
    step("post.f", 4'd0, V_FETCH);
    step("post.d", 4'd1, V_DEC);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
